// File: rtl/rf_write_arbiter.sv
// Two-port round-robin arbiter in front of the register file's single write port.
// The winning request is registered and presented to the register file one cycle after acceptance.
module rf_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} port_e;

  port_e last_grant;
  logic  both_valid;
  logic  grant_a;
  logic  grant_b;
  logic  we_q;

  // Grants depend only on the valids and registered pointer, never on rf_* outputs.
  always_comb begin
    both_valid = a_valid && b_valid;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    if (!reset) begin
      if (both_valid) begin
        grant_a = (last_grant == GNT_B);
        grant_b = (last_grant == GNT_A);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // A reset arriving while a write is being presented squashes that write immediately.
  assign rf_we = we_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q         <= 1'b0;
      rf_rd        <= '0;
      rf_wdata     <= '0;
      last_grant   <= GNT_B;
      conflict_cnt <= '0;
    end else begin
      // x0 writes are accepted and consume the grant but never reach the register file.
      we_q <= (grant_a && (a_rd != '0)) || (grant_b && (b_rd != '0));
      if (grant_a) begin
        rf_rd      <= a_rd;
        rf_wdata   <= a_data;
        last_grant <= GNT_A;
      end else if (grant_b) begin
        rf_rd      <= b_rd;
        rf_wdata   <= b_data;
        last_grant <= GNT_B;
      end
      if (both_valid && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single-port writes, round-robin contests,
// x0 writes, reset squashing a pending write, and counter saturation.
module tb_rf_write_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_rd, b_rd;
  logic [DATA_W-1:0] a_data, b_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;

    // 1: reset for two cycles; readies stay low even with valids asserted
    #1;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    step();
    step();
    chk("rst_we", rf_we, 0);
    chk("rst_cnt", conflict_cnt, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_we", rf_we, 0);
    chk("idle_cnt", conflict_cnt, 0);
    chk("idle_a_ready", a_ready, 0);
    chk("idle_b_ready", b_ready, 0);

    // 2: A only
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'hDEAD;
    #1;
    chk("aonly_a_ready", a_ready, 1);
    chk("aonly_b_ready", b_ready, 0);
    step();
    a_valid = 1'b0;
    chk("aonly_we", rf_we, 1);
    chk("aonly_rd", rf_rd, 5);
    chk("aonly_data", rf_wdata, 64'hDEAD);

    // B only, which also leaves the pointer at B so the next contest goes to A
    b_valid = 1'b1; b_rd = 5'd7; b_data = 64'hBEEF;
    #1;
    chk("bonly_b_ready", b_ready, 1);
    chk("bonly_a_ready", a_ready, 0);
    step();
    b_valid = 1'b0;
    chk("bonly_we", rf_we, 1);
    chk("bonly_rd", rf_rd, 7);
    chk("bonly_data", rf_wdata, 64'hBEEF);

    // 3: four contested cycles -> A,B,A,B with rf_we continuously high
    a_rd = 5'd1; a_data = 64'h11; b_rd = 5'd2; b_data = 64'h22;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
      step();
      chk("rr_we", rf_we, 1);
      chk("rr_rd", rf_rd, (i % 2 == 0) ? 1 : 2);
      chk("rr_data", rf_wdata, (i % 2 == 0) ? 64'h11 : 64'h22);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("rr_cnt", conflict_cnt, 4);

    // 4: write to x0 is accepted but not committed; pointer still moves to A
    a_valid = 1'b1; a_rd = 5'd0; a_data = 64'h77;
    #1;
    chk("x0_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("x0_we", rf_we, 0);
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h33;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 64'h44;
    #1;
    chk("x0_next_b_ready", b_ready, 1);
    chk("x0_next_a_ready", a_ready, 0);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("x0_next_we", rf_we, 1);
    chk("x0_next_rd", rf_rd, 4);
    chk("x0_next_cnt", conflict_cnt, 5);

    // 5: A accepted at N, reset during N+1 squashes the pending write
    a_valid = 1'b1; a_rd = 5'd9; a_data = 64'h99;
    #1;
    chk("rstmid_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0; reset = 1'b1;
    #1;
    chk("rstmid_we_n1", rf_we, 0);
    step();
    reset = 1'b0;
    chk("rstmid_we_n2", rf_we, 0);
    chk("rstmid_cnt", conflict_cnt, 0);
    a_rd = 5'd10; a_data = 64'hAA; b_rd = 5'd11; b_data = 64'hBB;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rstmid_contest_a", a_ready, 1);
    chk("rstmid_contest_b", b_ready, 0);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("rstmid_contest_rd", rf_rd, 10);
    chk("rstmid_contest_data", rf_wdata, 64'hAA);

    // 6: saturation of the 4-bit conflict counter over 2^4+3 contested cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      chk("sat_cnt", conflict_cnt, (i + 1 > 15) ? 15 : i + 1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("sat_hold", conflict_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
